// File: rtl/conv_window_controller_pkg.sv
// Shared types and sizing for the convolution window controller.
package conv_window_controller_pkg;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_KERNEL_SIZE = 5;
   localparam int DEF_IMAGE_SIZE  = 28;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   function automatic int out_size(input int image_size, input int kernel_size);
      return image_size - kernel_size + 1;
   endfunction

   localparam int OUT_SIZE = out_size(DEF_IMAGE_SIZE, DEF_KERNEL_SIZE);
   localparam int POS_W    = $clog2(DEF_IMAGE_SIZE);
   localparam int WIN_W    = $clog2(OUT_SIZE);

endpackage

// File: rtl/conv_window_controller_raster_counter.sv
// Row/column raster position of the next pixel to enter the bank.
module conv_window_controller_raster_counter #(
   parameter int SIZE = 28,
   parameter int W    = $clog2(SIZE)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] row,
   output logic [W-1:0] col,
   output logic         last
);

   localparam logic [W-1:0] MAX = W'(SIZE - 1);

   assign last = (row == MAX) && (col == MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (col == MAX) begin
            col <= '0;
            row <= (row == MAX) ? '0 : row + W'(1);
         end else begin
            col <= col + W'(1);
         end
      end
   end

endmodule

// File: rtl/conv_window_controller.sv
// Sequences one KxK window pass over an NxN frame: weight load, pixel stream, window flagging.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | waiting for start, counters cleared
//  ST_LOAD   | w_ready high, waiting for the weight handshake
//  ST_STREAM | accepting pixels, presenting windows downstream
//  ST_DONE   | one-cycle done pulse, then back to idle
module conv_window_controller
   import conv_window_controller_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE,
   localparam int OUT_N      = out_size(IMAGE_SIZE, KERNEL_SIZE),
   localparam int PW         = $clog2(IMAGE_SIZE),
   localparam int WW         = $clog2(OUT_N)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  w_valid,
   output logic                  w_ready,
   output logic                  bank_write,
   input  logic                  pix_valid,
   input  logic [DATA_WIDTH-1:0] pix_data,
   output logic                  pix_ready,
   output logic                  bank_shift,
   output logic [DATA_WIDTH-1:0] bank_pixel,
   output logic                  win_valid,
   input  logic                  win_ready,
   output logic [WW-1:0]         win_row,
   output logic [WW-1:0]         win_col,
   output logic                  busy,
   output logic                  done
);

   localparam logic [PW-1:0] EDGE = PW'(KERNEL_SIZE - 1);

   state_t        state, state_nxt;
   logic          exhausted;
   logic [PW-1:0] row, col;
   logic          last;
   logic          qualify;
   logic          cnt_clear;

   conv_window_controller_raster_counter #(
      .SIZE (IMAGE_SIZE),
      .W    (PW)
   ) u_raster (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .en    (bank_shift),
      .row   (row),
      .col   (col),
      .last  (last)
   );

   // A held, unconsumed window stalls the stream so the bank never shifts under it.
   assign pix_ready  = (state == ST_STREAM) && !exhausted && !(win_valid && !win_ready);
   assign bank_shift = pix_valid && pix_ready;
   assign bank_pixel = pix_data;
   assign w_ready    = (state == ST_LOAD);
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);
   assign qualify    = (row >= EDGE) && (col >= EDGE);
   assign cnt_clear  = abort || (state != ST_STREAM);

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (start) state_nxt = ST_LOAD;
            ST_LOAD:   if (w_valid) state_nxt = ST_STREAM;
            ST_STREAM: if (exhausted && win_valid && win_ready) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         bank_write <= 1'b0;
         exhausted  <= 1'b0;
         win_valid  <= 1'b0;
         win_row    <= '0;
         win_col    <= '0;
      end else begin
         state      <= state_nxt;
         bank_write <= !abort && (state == ST_LOAD) && w_valid;
         if (abort || (state != ST_STREAM)) begin
            exhausted <= 1'b0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
         end else begin
            if (bank_shift && last) exhausted <= 1'b1;
            if (bank_shift && qualify) begin
               win_valid <= 1'b1;
               win_row   <= WW'(row - EDGE);
               win_col   <= WW'(col - EDGE);
            end else if (win_ready) begin
               win_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_window_controller.sv
// Directed bench for conv_window_controller with a small cycle model of the window stream.
module tb_conv_window_controller;

   localparam int DW  = 16;
   localparam int K   = 5;
   localparam int N   = 28;
   localparam int OUT = N - K + 1;
   localparam int WW  = $clog2(OUT);

   logic          clk;
   logic          reset;
   logic          start;
   logic          abort;
   logic          w_valid;
   logic          w_ready;
   logic          bank_write;
   logic          pix_valid;
   logic [DW-1:0] pix_data;
   logic          pix_ready;
   logic          bank_shift;
   logic [DW-1:0] bank_pixel;
   logic          win_valid;
   logic          win_ready;
   logic [WW-1:0] win_row;
   logic [WW-1:0] win_col;
   logic          busy;
   logic          done;

   int checks   = 0;
   int failures = 0;

   conv_window_controller #(
      .DATA_WIDTH  (DW),
      .KERNEL_SIZE (K),
      .IMAGE_SIZE  (N)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .bank_write (bank_write),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_ready  (pix_ready),
      .bank_shift (bank_shift),
      .bank_pixel (bank_pixel),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_row    (win_row),
      .win_col    (win_col),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int outs_packed();
      return int'({busy, done, w_ready, bank_write, pix_ready, bank_shift,
                   win_valid, win_row, win_col}) | int'(bank_pixel);
   endfunction

   task automatic start_frame(input int idle_w);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("load_w_ready", int'(w_ready), 1);
      chk("load_busy", int'(busy), 1);
      for (int i = 0; i < idle_w; i++) @(negedge clk);
      w_valid = 1'b1;
      @(negedge clk);
      w_valid = 1'b0;
      #1;
      chk("bank_write_pulse", int'(bank_write), 1);
      chk("stream_w_ready", int'(w_ready), 0);
   endtask

   // Drives a whole frame, models expected pix_ready/win_valid/coords per cycle,
   // and stalls the consumer for 10 cycles on window (5,7).
   task automatic run_stream(input bit rnd);
      int pcnt = 0, wcnt = 0, errs = 0, cyc = 0, dones = 0, bw = 0;
      int stall = 0, stall_ok = 0, first_p = -1, first_rc = -1, last_rc = -1, wrap_p = -1;
      bit ewv = 1'b0, exp_pr, consumed;
      int er = 0, ec = 0, r, c;
      while (dones == 0 && cyc < 6000) begin
         @(negedge clk);
         pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         pix_data  = DW'(pcnt * 7 + 3);
         win_ready = !(win_valid && win_row == 5 && win_col == 7 && stall < 10);
         #1;
         exp_pr = (pcnt < N * N) && !(ewv && !win_ready);
         if (pix_ready !== exp_pr) errs++;
         if (bank_shift !== (pix_valid && exp_pr)) errs++;
         if (bank_pixel !== pix_data) errs++;
         if (win_valid !== ewv) errs++;
         if (ewv && (int'(win_row) != er || int'(win_col) != ec)) errs++;
         if (bank_write) bw++;
         if (done) dones++;
         if (!win_ready) begin
            stall++;
            if (!pix_ready && !bank_shift && win_row == 5 && win_col == 7) stall_ok++;
         end
         if (win_valid && first_p < 0) begin
            first_p  = pcnt;
            first_rc = int'(win_row) * 32 + int'(win_col);
         end
         if (win_valid && win_row == 1 && win_col == 0 && wrap_p < 0) wrap_p = pcnt;
         consumed = ewv && win_ready;
         if (consumed) begin
            if (er * OUT + ec != wcnt) errs++;
            last_rc = int'(win_row) * 32 + int'(win_col);
            wcnt++;
         end
         if (pix_valid && exp_pr) begin
            r = pcnt / N;
            c = pcnt % N;
            if (r >= K - 1 && c >= K - 1) begin
               ewv = 1'b1;
               er  = r - (K - 1);
               ec  = c - (K - 1);
            end else if (consumed) begin
               ewv = 1'b0;
            end
            pcnt++;
         end else if (consumed) begin
            ewv = 1'b0;
         end
         cyc++;
      end
      pix_valid = 1'b0;
      win_ready = 1'b1;
      chk("window_count", wcnt, OUT * OUT);
      chk("cycle_model_errs", errs, 0);
      chk("pixels_accepted", pcnt, N * N);
      chk("first_win_after_px", first_p, 117);
      chk("first_win_rc", first_rc, 0);
      chk("last_win_rc", last_rc, 23 * 32 + 23);
      chk("row_wrap_first_px", wrap_p, 5 * N + 4 + 1);
      chk("stall_cycles", stall, 10);
      chk("stall_hold", stall_ok, 10);
      chk("bank_write_in_stream", bw, 0);
      chk("done_pulses", dones, 1);
      @(negedge clk);
      #1;
      chk("done_one_cycle", int'(done), 0);
      chk("idle_after_done", int'(busy), 0);
   endtask

   initial begin
      int cnt;
      reset     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      w_valid   = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      win_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", outs_packed(), 0);
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("idle_busy", int'(busy), 0);

      start_frame(3);
      run_stream(1'b0);

      start_frame(1);
      run_stream(1'b1);

      // abort during LOAD with a weight offered on the same edge
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      w_valid = 1'b1;
      abort   = 1'b1;
      @(negedge clk);
      w_valid = 1'b0;
      abort   = 1'b0;
      #1;
      chk("abort_load_busy", int'(busy), 0);
      chk("abort_load_bank_write", int'(bank_write), 0);

      // abort during STREAM; a start mid-stream must be ignored
      start_frame(0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         pix_valid = 1'b1;
         pix_data  = DW'(i);
         start     = (i == 10);
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("start_in_stream_w_ready", int'(w_ready), 0);
      chk("start_in_stream_busy", int'(busy), 1);
      abort = 1'b1;
      @(negedge clk);
      abort     = 1'b0;
      pix_valid = 1'b0;
      #1;
      chk("abort_stream_busy", int'(busy), 0);
      chk("abort_stream_win_valid", int'(win_valid), 0);
      chk("abort_stream_done", int'(done), 0);

      // reset mid-stream after 100 pixels, then a clean frame
      start_frame(0);
      cnt = 0;
      for (int i = 0; i < 400 && cnt < 100; i++) begin
         @(negedge clk);
         pix_valid = 1'b1;
         pix_data  = DW'(cnt + 1);
         win_ready = 1'b1;
         #1;
         if (bank_shift) cnt++;
      end
      chk("pixels_before_reset", cnt, 100);
      @(negedge clk);
      reset     = 1'b1;
      pix_valid = 1'b0;
      pix_data  = '0;
      @(negedge clk);
      #1;
      chk("mid_reset_outputs", outs_packed(), 0);
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("after_reset_busy", int'(busy), 0);
      start_frame(3);
      run_stream(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
